// File: rtl/stack_ctrl_pkg.sv
// Shared types and defaults for the RPN stack command sequencer.
package stack_ctrl_pkg;

  localparam int unsigned DefaultWidth = 10;
  localparam int unsigned DefaultDepth = 7;

  typedef enum logic [2:0] {
    OpPush = 3'b000,
    OpPop  = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpAnd  = 3'b100,
    OpOr   = 3'b101,
    OpXor  = 3'b110,
    OpDup  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPopA  = 3'd1,
    StPopB  = 3'd2,
    StPushR = 3'd3,
    StPush2 = 3'd4
  } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/result handshake plus stack-side strobes of the stack sequencer.
// master: command source and stack block; slave: the sequencer itself.
interface stack_ctrl_if
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
);
  localparam int unsigned DepthW = $clog2(DEPTH + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_imm;
  logic              st_push;
  logic [WIDTH-1:0]  st_indata;
  logic              st_pop;
  logic [WIDTH-1:0]  st_outdata;
  logic              res_valid;
  logic [WIDTH-1:0]  res_data;
  logic              err;
  logic [DepthW-1:0] depth;

  modport master (
    output cmd_valid, cmd_op, cmd_imm, st_outdata,
    input  cmd_ready, st_push, st_indata, st_pop, res_valid, res_data, err, depth
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm, st_outdata,
    output cmd_ready, st_push, st_indata, st_pop, res_valid, res_data, err, depth
  );

endinterface

// File: rtl/stack_ctrl_alu.sv
// Combinational f(op, B, A) for the sequencer; B is the deeper operand.
// Saturating ADD/SUB when STACK_CTRL_SAT_EN is defined, wrap-around otherwise.
module stack_ctrl_alu
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] result,
  output logic             sat
);

`ifdef STACK_CTRL_SAT_EN
  logic [WIDTH:0] sum;
  assign sum = {1'b0, b} + {1'b0, a};
`endif

  always_comb begin
    result = a;
    sat    = 1'b0;
    unique case (op)
      OpAdd: begin
`ifdef STACK_CTRL_SAT_EN
        result = sum[WIDTH-1:0];
        if (sum[WIDTH]) begin
          result = '1;
          sat    = 1'b1;
        end
`else
        result = b + a;
`endif
      end
      OpSub: begin
        result = b - a;
`ifdef STACK_CTRL_SAT_EN
        if (a > b) begin
          result = '0;
          sat    = 1'b1;
        end
`endif
      end
      OpAnd:   result = b & a;
      OpOr:    result = b | a;
      OpXor:   result = b ^ a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/stack_ctrl.sv
// RPN command sequencer driving a LIFO stack: FSM, depth tracking, operand and result registers.
// Build option: define STACK_CTRL_SAT_EN for saturating ADD/SUB with err on clamp.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input logic         clk,
  input logic         rst,
  stack_ctrl_if.slave bus
);

  localparam int unsigned DepthW = $clog2(DEPTH + 1);

  state_e            state_q;
  op_e               op_q;
  op_e               new_op;
  logic [WIDTH-1:0]  a_q;
  logic [DepthW-1:0] depth_q;
  logic              cmd_ready_q;
  logic              st_push_q;
  logic              st_pop_q;
  logic [WIDTH-1:0]  st_indata_q;
  logic              res_valid_q;
  logic [WIDTH-1:0]  res_data_q;
  logic              err_q;
  logic              accept_ok;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_sat;

  assign new_op = op_e'(bus.cmd_op);

  always_comb begin
    accept_ok = 1'b0;
    unique case (new_op)
      OpPush:  accept_ok = depth_q < DepthW'(DEPTH);
      OpPop:   accept_ok = depth_q != '0;
      OpDup:   accept_ok = (depth_q != '0) && (depth_q < DepthW'(DEPTH));
      default: accept_ok = depth_q >= DepthW'(2);
    endcase
  end

  // B is taken straight from the stack top while POP_B strobes.
  stack_ctrl_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op    (op_q),
    .b     (bus.st_outdata),
    .a     (a_q),
    .result(alu_res),
    .sat   (alu_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpPush;
      a_q         <= '0;
      depth_q     <= '0;
      cmd_ready_q <= 1'b1;
      st_push_q   <= 1'b0;
      st_pop_q    <= 1'b0;
      st_indata_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      st_push_q   <= 1'b0;
      st_pop_q    <= 1'b0;
      st_indata_q <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      // Depth follows the strobes actually issued, so it is exact whenever IDLE checks it.
      depth_q     <= depth_q + DepthW'(st_push_q) - DepthW'(st_pop_q);

      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q        <= new_op;
            cmd_ready_q <= 1'b0;
            if (!accept_ok) begin
              err_q <= 1'b1;
            end else if (new_op == OpPush) begin
              state_q     <= StPushR;
              st_push_q   <= 1'b1;
              st_indata_q <= bus.cmd_imm;
            end else begin
              state_q  <= StPopA;
              st_pop_q <= 1'b1;
            end
          end
        end
        StPopA: begin
          a_q <= bus.st_outdata;
          if (op_q == OpPop) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b1;
            res_data_q  <= bus.st_outdata;
          end else if (op_q == OpDup) begin
            state_q     <= StPushR;
            st_push_q   <= 1'b1;
            st_indata_q <= bus.st_outdata;
          end else begin
            state_q  <= StPopB;
            st_pop_q <= 1'b1;
          end
        end
        StPopB: begin
          state_q     <= StPushR;
          st_push_q   <= 1'b1;
          st_indata_q <= alu_res;
          res_valid_q <= 1'b1;
          res_data_q  <= alu_res;
          err_q       <= alu_sat;
        end
        StPushR: begin
          if (op_q == OpDup) begin
            state_q     <= StPush2;
            st_push_q   <= 1'b1;
            st_indata_q <= a_q;
          end else begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
          end
        end
        StPush2: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.st_push   = st_push_q;
  assign bus.st_pop    = st_pop_q;
  assign bus.st_indata = st_indata_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.err       = err_q;
  assign bus.depth     = depth_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomised bench for stack_ctrl: a 7-entry stack model answers the strobes and a
// transaction-level RPN model predicts latency, strobes, results, err and depth.
module tb_stack_ctrl;

  localparam int W    = 10;
  localparam int D    = 7;
  localparam int Mask = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stack_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

  stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Stack block model driven by the DUT strobes.
  logic [W-1:0] mem [8];
  int           sp;

  assign bus.st_outdata = (sp > 0) ? mem[sp-1] : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
    end else begin
      if (bus.st_push) begin
        check("stk_no_overflow", int'(sp < D), 1);
        if (sp < 8) mem[sp] <= bus.st_indata;
        if (sp < 8) sp <= sp + 1;
      end
      if (bus.st_pop) begin
        check("stk_no_underflow", int'(sp > 0), 1);
        if (sp > 0) sp <= sp - 1;
      end
    end
  end

  // Reference model state.
  int unsigned ref_stk[$];
  int unsigned last_res;

  function automatic void ref_alu(input int op, input int unsigned b, input int unsigned a,
                                  output int unsigned r, output bit sat);
    sat = 1'b0;
    case (op)
      2: begin
        r = b + a;
        if (r > Mask) begin
`ifdef STACK_CTRL_SAT_EN
          r   = Mask;
          sat = 1'b1;
`else
          r   = r - (Mask + 1);
`endif
        end
      end
      3: begin
        if (a > b) begin
`ifdef STACK_CTRL_SAT_EN
          r   = 0;
          sat = 1'b1;
`else
          r   = b + (Mask + 1) - a;
`endif
        end else begin
          r = b - a;
        end
      end
      4:       r = b & a;
      5:       r = b | a;
      6:       r = b ^ a;
      default: r = a;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, bus.cmd_ready, 1);
    check({tag, "_push"}, bus.st_push, 0);
    check({tag, "_pop"}, bus.st_pop, 0);
    check({tag, "_indata"}, bus.st_indata, 0);
    check({tag, "_rvalid"}, bus.res_valid, 0);
    check({tag, "_rdata"}, bus.res_data, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_depth"}, bus.depth, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    ref_stk.delete();
    last_res = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issue one command (entered and left at #1 after a posedge) and check the whole transaction.
  task automatic do_cmd(input int op, input int unsigned imm);
    int          n = ref_stk.size();
    bit          ok;
    int          e_lat, e_push, e_pop, e_res_cyc, e_err_cyc;
    int unsigned e_res, a, b;
    bit          sat;
    int          o_lat, o_push, o_pop, o_res_cyc, o_err_cyc, o_res_cnt, o_err_cnt;
    int unsigned o_res;

    case (op)
      0:       ok = n < D;
      1:       ok = n >= 1;
      7:       ok = (n >= 1) && (n < D);
      default: ok = n >= 2;
    endcase
    e_res_cyc = 0;
    e_err_cyc = 0;
    e_res     = 0;
    e_push    = 0;
    e_pop     = 0;
    if (!ok) begin
      e_lat     = 2;
      e_err_cyc = 1;
    end else begin
      case (op)
        0: begin
          e_lat  = 2;
          e_push = 1;
          ref_stk.push_back(imm & Mask);
        end
        1: begin
          e_lat     = 2;
          e_pop     = 1;
          e_res     = ref_stk.pop_back();
          e_res_cyc = 2;
          last_res  = e_res;
        end
        7: begin
          e_lat  = 4;
          e_pop  = 1;
          e_push = 2;
          ref_stk.push_back(ref_stk[$]);
        end
        default: begin
          e_lat  = 4;
          e_pop  = 2;
          e_push = 1;
          a = ref_stk.pop_back();
          b = ref_stk.pop_back();
          ref_alu(op, b, a, e_res, sat);
          ref_stk.push_back(e_res);
          e_res_cyc = 3;
          last_res  = e_res;
          if (sat) e_err_cyc = 3;
        end
      endcase
    end

    for (int i = 0; i < 20 && !bus.cmd_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_imm   = W'(imm);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_imm   = W'($urandom);

    o_lat = 0; o_push = 0; o_pop = 0; o_res_cyc = 0; o_err_cyc = 0;
    o_res_cnt = 0; o_err_cnt = 0; o_res = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      check("strobe_excl", int'(bus.st_push && bus.st_pop), 0);
      if (!bus.st_push) check("indata_idle_zero", bus.st_indata, 0);
      o_push += int'(bus.st_push);
      o_pop  += int'(bus.st_pop);
      if (bus.res_valid) begin
        o_res_cnt++;
        o_res_cyc = cyc;
        o_res     = bus.res_data;
      end
      if (bus.err) begin
        o_err_cnt++;
        o_err_cyc = cyc;
      end
      if (bus.cmd_ready) begin
        o_lat = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end

    check("latency", o_lat, e_lat);
    check("push_count", o_push, e_push);
    check("pop_count", o_pop, e_pop);
    check("res_pulses", o_res_cnt, int'(e_res_cyc != 0));
    check("res_cycle", o_res_cyc, e_res_cyc);
    if (e_res_cyc != 0) check("res_value", o_res, e_res);
    check("err_pulses", o_err_cnt, int'(e_err_cyc != 0));
    check("err_cycle", o_err_cyc, e_err_cyc);
    check("res_held", bus.res_data, last_res);
    check("depth", bus.depth, ref_stk.size());
    check("stack_size", sp, ref_stk.size());
    if (ref_stk.size() > 0 && sp > 0) check("stack_top", mem[sp-1], ref_stk[$]);
  endtask

  initial begin
    int op;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_imm   = '0;
    last_res      = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_cmd(1, 0);
    do_cmd(0, 5);
    do_cmd(0, 3);
    do_cmd(3, 0);
    check("plan_sub_5_3", bus.res_data, 2);

    apply_reset();
    for (int i = 1; i <= 7; i++) do_cmd(0, i);
    do_cmd(0, 8);
    check("plan_full_depth", bus.depth, 7);
    do_cmd(1, 0);
    check("plan_pop_7", bus.res_data, 7);

    apply_reset();
    do_cmd(0, 1000);
    do_cmd(0, 100);
    do_cmd(2, 0);
`ifdef STACK_CTRL_SAT_EN
    check("plan_add_sat", bus.res_data, 1023);
`else
    check("plan_add_wrap", bus.res_data, 76);
`endif
    do_cmd(0, 0);
    do_cmd(0, 1);
    do_cmd(3, 0);
`ifdef STACK_CTRL_SAT_EN
    check("plan_sub_sat", bus.res_data, 0);
`else
    check("plan_sub_wrap", bus.res_data, 1023);
`endif

    apply_reset();
    do_cmd(0, 'h155);
    do_cmd(7, 0);
    do_cmd(6, 0);
    check("plan_dup_xor", bus.res_data, 0);
    check("plan_dup_depth", bus.depth, 1);
    do_cmd(0, 'h3F0);
    do_cmd(0, 'h0FF);
    do_cmd(4, 0);
    check("plan_and", bus.res_data, 'h0F0);
    do_cmd(0, 'h3F0);
    do_cmd(0, 'h0FF);
    do_cmd(5, 0);
    check("plan_or", bus.res_data, 'h3FF);

    // Reset while an ADD sits in POP_B.
    apply_reset();
    do_cmd(0, 11);
    do_cmd(0, 22);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd2;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_popb_strobe", bus.st_pop, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    ref_stk.delete();
    last_res = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_cmd(1, 0);

    apply_reset();
    for (int k = 0; k < 400; k++) begin
      op = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 7));
      do_cmd(op, $urandom_range(0, Mask));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
